// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package sipo_pkg;

   // Output holding register occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Width of the bit counter: enough to hold 0..WIDTH-1 plus one spare bit.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: assembles serial bits into a word and
// flags the edge on which the last bit of a word is sampled.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CW        = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             serial_in,
   input  logic             serial_valid,
   output logic             word_done,
   output logic [WIDTH-1:0] next_word,
   output logic [CW-1:0]    bit_count
);

   // Only WIDTH-1 bits need storing; the final bit comes straight from serial_in.
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-2:0] shreg_nxt;

   generate
      if (MSB_FIRST) begin : g_msb
         // First bit ends up at the top after WIDTH left shifts.
         assign next_word = {shreg, serial_in};
         assign shreg_nxt = next_word[WIDTH-2:0];
      end else begin : g_lsb
         // First bit ends up at the bottom after WIDTH right shifts.
         assign next_word = {serial_in, shreg};
         assign shreg_nxt = next_word[WIDTH-1:1];
      end
   endgenerate

   // A frame restart suppresses the strobe in the same cycle.
   assign word_done = serial_valid & ~clr & (bit_count == CW'(WIDTH - 1));

   // Shift on every qualified strobe; counter wraps on word completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg     <= '0;
         bit_count <= '0;
      end else if (clr) begin
         shreg     <= '0;
         bit_count <= '0;
      end else if (serial_valid) begin
         shreg     <= shreg_nxt;
         bit_count <= word_done ? '0 : bit_count + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a single-entry valid/ready output
// and a sticky flag for words dropped while the consumer stalls.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in,
   input  logic                        serial_valid,
   input  logic                        sync_clr,
   output logic [WIDTH-1:0]            parallel_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        overrun,
   output logic [cnt_width(WIDTH)-1:0] bit_count
);

   localparam int CW = cnt_width(WIDTH);

   logic             word_done;
   logic [WIDTH-1:0] next_word;
   out_state_t       state, state_nxt;
   logic             load;
   logic             drop;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
   ) u_core (
      .clk          (clk),
      .reset        (reset),
      .clr          (sync_clr),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .word_done    (word_done),
      .next_word    (next_word),
      .bit_count    (bit_count)
   );

   assign out_valid = (state == FULL);

   // Output state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= state_nxt;
   end

   // Next state: a handshake frees the slot in the same edge a new word may claim it.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      drop      = 1'b0;
      unique case (state)
         EMPTY: begin
            if (word_done) begin
               state_nxt = FULL;
               load      = 1'b1;
            end
         end
         FULL: begin
            if (word_done) begin
               if (out_ready) load = 1'b1;
               else           drop = 1'b1;
            end else if (out_ready) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Holding register keeps its last word after consumption.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    parallel_out <= '0;
      else if (load) parallel_out <= next_word;
   end

   // Sticky loss flag, cleared only by a frame restart or reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        overrun <= 1'b0;
      else if (sync_clr) overrun <= 1'b0;
      else if (drop)     overrun <= 1'b1;
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench: two deserializers (MSB-first and LSB-first) fed the same stream,
// scoreboard queues filled as words are sent and drained on handshakes.
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       serial_in = 1'b0;
   logic       serial_valid = 1'b0;
   logic       sync_clr = 1'b0;
   logic       out_ready = 1'b0;

   logic [7:0] po_m, po_l;
   logic       val_m, val_l;
   logic       ovr_m, ovr_l;
   logic [3:0] bc_m, bc_l;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         prev_hs = 0;
   int         last_hs = 0;
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .sync_clr(sync_clr), .parallel_out(po_m), .out_valid(val_m), .out_ready(out_ready),
      .overrun(ovr_m), .bit_count(bc_m)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .sync_clr(sync_clr), .parallel_out(po_l), .out_valid(val_l), .out_ready(out_ready),
      .overrun(ovr_l), .bit_count(bc_l)
   );

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   // Queue the expected word for both bit orders.
   task automatic expect_word(input logic [7:0] w);
      q_m.push_back(w);
      q_l.push_back(rev8(w));
   endtask

   // One cycle: drive inputs, score any handshake happening at the coming edge, advance.
   task automatic sbit(input logic b, input logic v);
      logic [7:0] e;
      serial_in    = b;
      serial_valid = v;
      if (val_m && out_ready) begin
         total++;
         if (q_m.size() == 0) begin
            bad++;
            $display("FAIL sb_msb_unexpected got=%h exp=none", po_m);
         end else begin
            e = q_m.pop_front();
            if (po_m !== e) begin
               bad++;
               $display("FAIL sb_msb_word got=%h exp=%h", po_m, e);
            end
         end
         prev_hs = last_hs;
         last_hs = cyc;
      end
      if (val_l && out_ready) begin
         total++;
         if (q_l.size() == 0) begin
            bad++;
            $display("FAIL sb_lsb_unexpected got=%h exp=none", po_l);
         end else begin
            e = q_l.pop_front();
            if (po_l !== e) begin
               bad++;
               $display("FAIL sb_lsb_word got=%h exp=%h", po_l, e);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_word(input logic [7:0] w, input bit gapped);
      for (int i = 7; i >= 0; i--) begin
         if (gapped) sbit(1'b0, 1'b0);
         sbit(w[i], 1'b1);
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({po_m, val_m, ovr_m, bc_m} !== 14'd0) begin
         bad++;
         $display("FAIL reset_msb got=%h/%b/%b/%h exp=0", po_m, val_m, ovr_m, bc_m);
      end
      total++;
      if ({po_l, val_l, ovr_l, bc_l} !== 14'd0) begin
         bad++;
         $display("FAIL reset_lsb got=%h/%b/%b/%h exp=0", po_l, val_l, ovr_l, bc_l);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_word_assembly();
      logic [7:0] w;
      w = 8'hB2;
      out_ready = 1'b1;
      expect_word(w);
      for (int i = 7; i >= 1; i--) sbit(w[i], 1'b1);
      total++;
      if (val_m !== 1'b0 || bc_m !== 4'd7) begin
         bad++;
         $display("FAIL asm_before_last got=%b/%h exp=0/7", val_m, bc_m);
      end
      sbit(w[0], 1'b1);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'hB2 || bc_m !== 4'd0) begin
         bad++;
         $display("FAIL asm_msb got=%b/%h/%h exp=1/b2/0", val_m, po_m, bc_m);
      end
      total++;
      if (val_l !== 1'b1 || po_l !== 8'h4D) begin
         bad++;
         $display("FAIL asm_lsb got=%b/%h exp=1/4d", val_l, po_l);
      end
      sbit(1'b0, 1'b0);
      total++;
      if (val_m !== 1'b0 || val_l !== 1'b0) begin
         bad++;
         $display("FAIL asm_one_cycle got=%b/%b exp=0/0", val_m, val_l);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      expect_word(8'hA5);
      expect_word(8'h3C);
      send_word(8'hA5, 1'b0);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'hA5) begin
         bad++;
         $display("FAIL b2b_first got=%b/%h exp=1/a5", val_m, po_m);
      end
      send_word(8'h3C, 1'b0);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'h3C || po_l !== 8'h3C) begin
         bad++;
         $display("FAIL b2b_second got=%b/%h/%h exp=1/3c/3c", val_m, po_m, po_l);
      end
      sbit(1'b0, 1'b0);
      total++;
      if (last_hs - prev_hs !== 8 || ovr_m !== 1'b0 || val_m !== 1'b0) begin
         bad++;
         $display("FAIL b2b_spacing got=%0d/%b/%b exp=8/0/0", last_hs - prev_hs, ovr_m, val_m);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] w;
      out_ready = 1'b0;
      expect_word(8'h11);
      send_word(8'h11, 1'b0);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'h11) begin
         bad++;
         $display("FAIL bp_first got=%b/%h exp=1/11", val_m, po_m);
      end
      w = 8'h22;
      for (int i = 7; i >= 1; i--) sbit(w[i], 1'b1);
      total++;
      if (ovr_m !== 1'b0 || po_m !== 8'h11) begin
         bad++;
         $display("FAIL bp_before_16 got=%b/%h exp=0/11", ovr_m, po_m);
      end
      sbit(w[0], 1'b1);
      total++;
      if (ovr_m !== 1'b1 || ovr_l !== 1'b1 || po_m !== 8'h11 || val_m !== 1'b1 || bc_m !== 4'd0) begin
         bad++;
         $display("FAIL bp_overrun got=%b/%b/%h/%b/%h exp=1/1/11/1/0", ovr_m, ovr_l, po_m, val_m, bc_m);
      end
      out_ready = 1'b1;
      sbit(1'b0, 1'b0);
      total++;
      if (val_m !== 1'b0 || po_m !== 8'h11 || ovr_m !== 1'b1) begin
         bad++;
         $display("FAIL bp_drain got=%b/%h/%b exp=0/11/1", val_m, po_m, ovr_m);
      end
   endtask

   task automatic test_gapped_clr();
      out_ready = 1'b1;
      sbit(1'b1, 1'b1);
      sbit(1'b1, 1'b1);
      sbit(1'b1, 1'b1);
      total++;
      if (bc_m !== 4'd3) begin
         bad++;
         $display("FAIL clr_partial got=%h exp=3", bc_m);
      end
      sync_clr = 1'b1;
      sbit(1'b1, 1'b1);
      sync_clr = 1'b0;
      total++;
      if (bc_m !== 4'd0 || ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
         bad++;
         $display("FAIL clr_effect got=%h/%b/%b exp=0/0/0", bc_m, ovr_m, ovr_l);
      end
      expect_word(8'hF0);
      send_word(8'hF0, 1'b1);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'hF0 || po_l !== 8'h0F || bc_m !== 4'd0 || ovr_m !== 1'b0) begin
         bad++;
         $display("FAIL clr_word got=%b/%h/%h/%h/%b exp=1/f0/0f/0/0", val_m, po_m, po_l, bc_m, ovr_m);
      end
      sbit(1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) sbit(1'b1, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({po_m, val_m, ovr_m, bc_m} !== 14'd0 || {po_l, bc_l} !== 12'd0) begin
         bad++;
         $display("FAIL areset got=%h/%b/%b/%h exp=0", po_m, val_m, ovr_m, bc_m);
      end
      #1;
      reset = 1'b1;
      expect_word(8'h81);
      send_word(8'h81, 1'b0);
      total++;
      if (val_m !== 1'b1 || po_m !== 8'h81 || po_l !== 8'h81) begin
         bad++;
         $display("FAIL areset_word got=%b/%h/%h exp=1/81/81", val_m, po_m, po_l);
      end
      sbit(1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_word_assembly();
      test_back_to_back();
      test_backpressure();
      test_gapped_clr();
      test_async_reset();
      total++;
      if (q_m.size() != 0 || q_l.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d/%0d exp=0/0", q_m.size(), q_l.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
